// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// DIVIDER_SIGNED_EN (see seq_restoring_divider) does not affect this file.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/carry_look_ahead_16bit.sv
// N-bit carry-lookahead adder built from 4-bit lookahead groups.
// The divider uses it as a subtractor (b_in = ~D, c_in = 1).
module carry_look_ahead_16bit #(
   parameter int N = 16
) (
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         c_in,
   output logic [N-1:0] sum_out,
   output logic         c_out
);

   localparam int NG = N / 4;

   logic [N-1:0]  w_g;
   logic [N-1:0]  w_p;
   logic [N:0]    w_c;
   logic [NG-1:0] w_gg;
   logic [NG-1:0] w_gp;

   assign w_g = a_in & b_in;
   assign w_p = a_in ^ b_in;

   always_comb begin
      w_c    = '0;
      w_gg   = '0;
      w_gp   = '0;
      w_c[0] = c_in;
      for (int i = 0; i < NG; i++) begin
         w_gg[i] = w_g[4*i+3]
                 | (w_p[4*i+3] & w_g[4*i+2])
                 | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
                 | ((&w_p[4*i+3 -: 3]) & w_g[4*i]);
         w_gp[i] = &w_p[4*i+3 -: 4];
         w_c[4*i+1] = w_g[4*i]
                    | (w_p[4*i] & w_c[4*i]);
         w_c[4*i+2] = w_g[4*i+1]
                    | (w_p[4*i+1] & w_g[4*i])
                    | (w_p[4*i+1] & w_p[4*i] & w_c[4*i]);
         w_c[4*i+3] = w_g[4*i+2]
                    | (w_p[4*i+2] & w_g[4*i+1])
                    | (w_p[4*i+2] & w_p[4*i+1] & w_g[4*i])
                    | ((&w_p[4*i+2 -: 3]) & w_c[4*i]);
         // group carry skips the whole nibble
         w_c[4*i+4] = w_gg[i] | (w_gp[i] & w_c[4*i]);
      end
   end

   assign sum_out = w_p ^ w_c[N-1:0];
   assign c_out   = w_c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider, one trial subtraction per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         valid_in,
   output logic         ready_out,
   input  logic [N-1:0] dividend_in,
   input  logic [N-1:0] divisor_in,
   output logic         valid_out,
   input  logic         ready_in,
   output logic [N-1:0] quotient_out,
   output logic [N-1:0] remainder_out,
   output logic         div_by_zero_out
);

   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW-1:0] INC  = CW'(1);
   localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

   div_state_t r_state;
   div_state_t w_state_nxt;

   logic [N-1:0]  r_q;
   logic [N-1:0]  r_r;
   logic [N-1:0]  r_d;
   logic [N-1:0]  r_quo;
   logic [N-1:0]  r_rem;
   logic          r_dbz;
   logic [CW-1:0] r_cnt;

   logic [N-1:0]  w_t_lo;
   logic [N-1:0]  w_diff;
   logic [N-1:0]  w_q_nxt;
   logic [N-1:0]  w_r_nxt;
   logic [N-1:0]  w_q_fin;
   logic [N-1:0]  w_r_fin;
   logic [N-1:0]  w_dvd_mag;
   logic [N-1:0]  w_dvs_mag;
   logic          w_cout;
   logic          w_ok;
   logic          w_accept;
   logic          w_last;
   logic          w_zero;

`ifdef DIVIDER_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;
`endif

   assign w_t_lo = {r_r[N-2:0], r_q[N-1]};

   carry_look_ahead_16bit #(
      .N (N)
   ) u_sub (
      .a_in    (w_t_lo),
      .b_in    (~r_d),
      .c_in    (1'b1),
      .sum_out (w_diff),
      .c_out   (w_cout)
   );

   // r_r[N-1] is T[N]: the shifted partial remainder already exceeds D
   assign w_ok    = r_r[N-1] | w_cout;
   assign w_r_nxt = w_ok ? w_diff : w_t_lo;
   assign w_q_nxt = {r_q[N-2:0], w_ok};
   assign w_last  = (r_cnt == LAST);
   assign w_zero  = (divisor_in == '0);

   always_comb begin
      w_dvd_mag = dividend_in;
      w_dvs_mag = divisor_in;
      w_q_fin   = w_q_nxt;
      w_r_fin   = w_r_nxt;
`ifdef DIVIDER_SIGNED_EN
      if (dividend_in[N-1]) w_dvd_mag = ~dividend_in + ONE;
      if (divisor_in[N-1])  w_dvs_mag = ~divisor_in + ONE;
      if (r_neg_q)          w_q_fin   = ~w_q_nxt + ONE;
      if (r_neg_r)          w_r_fin   = ~w_r_nxt + ONE;
`endif
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_out   = 1'b0;
      valid_out   = 1'b0;
      w_accept    = 1'b0;
      unique case (r_state)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in) begin
               w_accept    = 1'b1;
               w_state_nxt = w_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            valid_out = 1'b1;
            if (ready_in) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_q   <= '0;
         r_r   <= '0;
         r_d   <= '0;
         r_cnt <= '0;
         r_quo <= '0;
         r_rem <= '0;
         r_dbz <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else if (w_accept) begin
         r_q   <= w_dvd_mag;
         r_d   <= w_dvs_mag;
         r_r   <= '0;
         r_cnt <= '0;
`ifdef DIVIDER_SIGNED_EN
         r_neg_q <= dividend_in[N-1] ^ divisor_in[N-1];
         r_neg_r <= dividend_in[N-1];
`endif
         if (w_zero) begin
            r_quo <= DIV0_QUOT[N-1:0];
            r_rem <= dividend_in;
            r_dbz <= 1'b1;
         end
      end else if (r_state == CALC) begin
         r_q   <= w_q_nxt;
         r_r   <= w_r_nxt;
         r_cnt <= r_cnt + INC;
         if (w_last) begin
            r_quo <= w_q_fin;
            r_rem <= w_r_fin;
            r_dbz <= 1'b0;
         end
      end
   end

   assign quotient_out    = r_quo;
   assign remainder_out   = r_rem;
   assign div_by_zero_out = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (N=16), directed vectors.
// Extra signed vectors are enabled with DIVIDER_SIGNED_EN.
module tb_seq_restoring_divider;

   localparam int N = 16;

   logic         clk;
   logic         rst_in;
   logic         valid_in;
   logic         ready_out;
   logic [N-1:0] dividend_in;
   logic [N-1:0] divisor_in;
   logic         valid_out;
   logic         ready_in;
   logic [N-1:0] quotient_out;
   logic [N-1:0] remainder_out;
   logic         div_by_zero_out;

   seq_restoring_divider #(
      .N (N)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .valid_in        (valid_in),
      .ready_out       (ready_out),
      .dividend_in     (dividend_in),
      .divisor_in      (divisor_in),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .quotient_out    (quotient_out),
      .remainder_out   (remainder_out),
      .div_by_zero_out (div_by_zero_out)
   );

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   seen   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every presented result against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_in && valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got q=%0h r=%0h expected none",
                     quotient_out, remainder_out);
         end else begin
            e = sb[0];
            if (!seen) begin
               seen = 1;
               chk("latency_cycle", cyc, e.due);
            end
            chk("quotient", int'(quotient_out), int'(e.q));
            chk("remainder", int'(remainder_out), int'(e.r));
            chk("div_by_zero", int'(div_by_zero_out), int'(e.dbz));
            if (ready_in) begin
               void'(sb.pop_front());
               seen = 0;
            end else begin
               chk("ready_out_in_done", int'(ready_out), 0);
            end
         end
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] q, input logic [N-1:0] r,
                       input logic dbz);
      exp_t e;
      for (int n = 0; n < 200 && !ready_out; n++) begin
         @(posedge clk);
         #1;
      end
      if (!ready_out) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got ready_out=0 expected 1");
      end
      dividend_in = a;
      divisor_in  = b;
      valid_in    = 1'b1;
      e.q   = q;
      e.r   = r;
      e.dbz = dbz;
      // zero divisor resolves on the accepting edge itself
      e.due = cyc + 1 + ((b == '0) ? 0 : N);
      sb.push_back(e);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && sb.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
         seen = 0;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready_out"}, int'(ready_out), 1);
      chk({tag, "_valid_out"}, int'(valid_out), 0);
      chk({tag, "_quotient"}, int'(quotient_out), 0);
      chk({tag, "_remainder"}, int'(remainder_out), 0);
      chk({tag, "_div_by_zero"}, int'(div_by_zero_out), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in      = 1'b1;
      valid_in    = 1'b0;
      ready_in    = 1'b1;
      dividend_in = '0;
      divisor_in  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_in = 1'b0;
      @(posedge clk);
      #1;

      send(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
      drain();
      send(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
      send(16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
      send(16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0);
`ifdef DIVIDER_SIGNED_EN
      send(16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
      send(16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
      send(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
      send(16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1);
`else
      send(16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0);
      send(16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE, 1'b0);
`endif
      drain();
      send(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
      drain();

      ready_in = 1'b0;
      send(16'd48, 16'd5, 16'd9, 16'd3, 1'b0);
      for (int n = 0; n < 100 && !valid_out; n++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_valid_seen", int'(valid_out), 1);
      dividend_in = 16'd77;
      divisor_in  = 16'd0;
      for (int i = 0; i < 5; i++) begin
         valid_in = ~i[0];
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_ready_after_release", int'(ready_out), 1);
      chk("bp_valid_after_release", int'(valid_out), 0);
      send(16'd200, 16'd10, 16'd20, 16'd0, 1'b0);
      drain();

      send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      rst_in = 1'b1;
      void'(sb.pop_back());
      seen = 0;
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      chk_reset_state("midop_reset");
      send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
      drain();

      repeat (3) @(posedge clk);
      #1;
      chk("no_spurious_valid", int'(valid_out), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
